spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI responder (slave) for the team's 16-bit SPI frames; peer of the in-house SPI master.
- Supports CPHA=1 modes only: mode 1 (CPOL=0) and mode 3 (CPOL=1).
- Oversamples spi_csn/spi_clk/spi_mosi on sys_clk and exchanges one 16-bit word per chip-select assertion, MSB first.
- Presents the received word and a one-cycle done strobe to user logic.

Parameters:
- DATA_W, 16, frame width in bits; bit counter is clog2(DATA_W)+1 bits wide.
- SYNC_STAGES, 2, synchroniser depth for spi_csn, spi_clk and spi_mosi (minimum 2).

Ports:
- sys_clk  in  1  system clock, 50 MHz; must be ≥ 8× SPI clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_mode  in  2  2'd1 = mode 1, 2'd3 = mode 3; bit[1] is CPOL; captured at frame start.
- spi_sdata  in  16  word to transmit; captured at frame start.
- spi_rdata  out  16  last fully received word.
- spi_done  out  1  one-cycle pulse: a 16-bit frame completed.
- spi_err  out  1  one-cycle pulse: frame aborted by spi_csn deassert before 16 bits.
- spi_busy  out  1  high from frame start until return to IDLE.
- spi_csn  in  1  chip select, active low, asynchronous to sys_clk.
- spi_clk  in  1  SPI clock from master.
- spi_mosi  in  1  data from master.
- spi_miso  out  1  data to master.
- spi_miso_oe  out  1  tristate enable for spi_miso; equals the synchronised (NOT spi_csn).

Behaviour:
- Reset values:
  - spi_rdata = 0; spi_done, spi_err, spi_busy, spi_miso, spi_miso_oe = 0.
  - State = IDLE; all synchroniser flops = 1 for csn, 0 for clk and mosi.
- Front end:
  - SYNC_STAGES flops on each input, plus one history flop on clk and csn.
  - cs_fall, cs_rise, sclk_rise and sclk_fall are single-cycle pulses.
  - Pin-to-detect latency is SYNC_STAGES+1 sys_clk cycles.
- Edge roles, with CPOL latched at frame start:
  - CPOL=0: lead = sclk_rise, trail = sclk_fall.
  - CPOL=1: lead = sclk_fall, trail = sclk_rise.
  - Lead edge launches a bit; trail edge samples one.
- IDLE:
  - spi_busy=0; spi_clk edges are ignored.
  - On cs_fall: latch spi_mode[1] into cpol_q and spi_sdata into tx_buf, clear bit_cnt and rx_buf.
  - Drive spi_miso <= spi_sdata[15] (bit pre-presented) and go to SHIFT.
- SHIFT (spi_busy=1):
  - On lead: spi_miso <= tx_buf[15]; tx_buf <= tx_buf << 1.
  - On trail: rx_buf <= {rx_buf[14:0], synchronised mosi}; bit_cnt <= bit_cnt+1.
  - On the trail that makes bit_cnt reach 16: spi_rdata <= {rx_buf[14:0], mosi}, spi_done=1 next cycle, go to HOLD.
  - lead and trail are never simultaneous; if cs_rise coincides with a trail edge, cs_rise wins.
- HOLD:
  - Frame complete; all SPI clock edges are ignored and spi_miso holds its last bit.
  - On cs_rise: go to IDLE.
  - Extra clocks while csn stays low produce no further done and no data change.
- Abort: cs_rise in SHIFT with bit_cnt<16 → pulse spi_err for 1 cycle, leave spi_rdata unchanged, go to IDLE.
- spi_miso_oe follows the synchronised csn, not the FSM.
- spi_done and spi_err are mutually exclusive; each lasts exactly 1 cycle.
- Mode changes while busy have no effect until the next cs_fall.
- spi_mode values 0 and 2 are unsupported; only bit[1] is used, so they behave as modes 1 and 3.
- Asynchronous reset mid-frame → immediately return to reset values. A csn low that persists after reset release produces no cs_fall, so the block stays in IDLE until csn rises and falls again.
- Frames back to back with a csn-high gap of ≥ SYNC_STAGES+2 sys_clk cycles must both complete.

Test Plan:
- Mode 1 exchange: spi_sdata=16'h3C5A, master sends 16'hA5C3 at 1 MHz → spi_rdata=16'hA5C3, master reads 16'h3C5A, exactly one spi_done pulse ~4 sys_clk after the 16th falling edge.
- Mode 3 exchange: spi_sdata=16'hFFFF then 16'h0001, master sends 16'h8000 then 16'h1234 → spi_rdata=16'h8000 then 16'h1234; master reads 16'hFFFF then 16'h0001.
- Abort: csn rises after 7 clocks → spi_err pulses once, no spi_done, spi_rdata keeps its previous value, spi_busy=0 four cycles later.
- Noise with csn high: 20 spi_clk toggles → no state change, spi_miso_oe=0, no done/err.
- Over-clocking: 18 clocks in one frame sending 16'hBEEF plus 2 extra bits → spi_rdata=16'hBEEF, one spi_done only.
- Reset mid-frame: rst_n low after 9 bits, released with csn still low → outputs at reset values, no done. The next full frame after a csn high-low cycle receives 16'h5555 correctly.

Source files
------------

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - CPHA=1 SPI responder exchanging one DATA_W-bit word per chip-select assertion
module spi_slave #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [1:0]        spi_mode,
  input  logic [DATA_W-1:0] spi_sdata,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_done,
  output logic              spi_err,
  output logic              spi_busy,
  input  logic              spi_csn,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Front-end synchronisers and edge history
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   csn_hist;
  logic                   clk_hist;
  logic [SYNC_STAGES-1:0] arm_pipe;
  logic                   armed;

  logic csn_s;
  logic clk_s;
  logic mosi_s;
  logic cs_fall;
  logic cs_rise;
  logic sclk_rise;
  logic sclk_fall;
  logic lead;
  logic trail;

  // FSM and datapath registers with their next values
  state_t              state_q, state_d;
  logic                cpol_q, cpol_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                miso_d;
  logic                done_d;
  logic                err_d;

  // Synchronise the three SPI pins and keep one history sample of csn and clk
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_sync  <= '1;
      clk_sync  <= '0;
      mosi_sync <= '0;
      csn_hist  <= 1'b1;
      clk_hist  <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csn_hist  <= csn_s;
      clk_hist  <= clk_s;
    end
  end

  // Arm chip-select edge detection only once csn has been seen high with the
  // synchroniser refilled from post-reset samples; a csn that stays low across
  // reset release therefore never looks like a frame start.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      arm_pipe <= {arm_pipe[SYNC_STAGES-2:0], 1'b1};
      armed    <= armed | (arm_pipe[SYNC_STAGES-1] & csn_s);
    end
  end

  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

  assign cs_fall   = armed & csn_hist & ~csn_s;
  assign cs_rise   = armed & ~csn_hist & csn_s;
  assign sclk_rise = ~clk_hist & clk_s;
  assign sclk_fall = clk_hist & ~clk_s;

  // With CPHA=1 the first edge after the idle level launches, the second samples
  assign lead      = cpol_q ? sclk_fall : sclk_rise;
  assign trail     = cpol_q ? sclk_rise : sclk_fall;

  assign spi_busy    = (state_q != ST_IDLE);
  assign spi_miso_oe = ~csn_s;

  // State and datapath register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      spi_rdata <= '0;
      spi_miso  <= 1'b0;
      spi_done  <= 1'b0;
      spi_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      spi_rdata <= rdata_d;
      spi_miso  <= miso_d;
      spi_done  <= done_d;
      spi_err   <= err_d;
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    rdata_d = spi_rdata;
    miso_d  = spi_miso;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          // Mode and transmit word are frozen for the whole frame; the MSB is
          // pre-presented so the master can sample it on the first trail edge.
          cpol_d  = spi_mode[1];
          tx_d    = spi_sdata;
          rx_d    = '0;
          cnt_d   = '0;
          miso_d  = spi_sdata[DATA_W-1];
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          // Chip select ending the frame takes priority over a coincident trail edge
          err_d   = (cnt_q < LAST_CNT);
          state_d = ST_IDLE;
        end else if (lead) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end else if (trail) begin
          rx_d  = {rx_q[DATA_W-2:0], mosi_s};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == LAST_CNT) begin
            rdata_d = {rx_q[DATA_W-2:0], mosi_s};
            done_d  = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // Surplus clocks are ignored until the master releases chip select
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave driving a CPHA=1 SPI master model
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 25;  // sys_clk cycles per SPI half period (1 MHz at 50 MHz)

  logic        sys_clk;
  logic        rst_n;
  logic [1:0]  spi_mode;
  logic [15:0] spi_sdata;
  logic [15:0] spi_rdata;
  logic        spi_done;
  logic        spi_err;
  logic        spi_busy;
  logic        spi_csn;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;

  spi_slave #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .spi_mode    (spi_mode),
    .spi_sdata   (spi_sdata),
    .spi_rdata   (spi_rdata),
    .spi_done    (spi_done),
    .spi_err     (spi_err),
    .spi_busy    (spi_busy),
    .spi_csn     (spi_csn),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // kind: 0 = no event, 1 = done, 2 = err
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] sdata;
    logic [15:0] mosi_w;
    int          nclk;
    int          kind;
    logic [15:0] exp_rdata;
    bit          chk_miso;
  } vec_t;

  typedef struct {
    int          kind;
    logic [15:0] rdata;
  } exp_t;

  vec_t        vecs [8];
  exp_t        exp_q [$];
  int          checks;
  int          failures;

  // Observed done/err events, written only by the monitor
  int          ev_kind  [64];
  logic [15:0] ev_rdata [64];
  int          ev_n;
  int          rd_idx;

  initial ev_n = 0;

  always @(negedge sys_clk) begin
    if (spi_done || spi_err) begin
      if (ev_n < 64) begin
        ev_kind[ev_n]  = {30'd0, spi_err, spi_done};
        ev_rdata[ev_n] = spi_rdata;
      end
      ev_n = ev_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  // Pop one expectation per observed event, then require nothing left outstanding
  task automatic drain();
    exp_t e;
    while (rd_idx < ev_n) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", ev_kind[rd_idx], 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", ev_kind[rd_idx], e.kind);
        chk("event_rdata", {16'd0, ev_rdata[rd_idx]}, {16'd0, e.rdata});
      end
      rd_idx = rd_idx + 1;
    end
    chk("missing_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // CPHA=1 master clocking: lead edge launches mosi, trail edge samples miso
  task automatic clk_bits(input logic cpol, input logic [15:0] w, input int first,
                          input int n, output logic [15:0] rd);
    logic [15:0] sh;
    sh = w << first;
    rd = '0;
    for (int i = 0; i < n; i++) begin
      spi_clk  = ~cpol;
      spi_mosi = sh[15];
      sh       = {sh[14:0], 1'b1};
      wait_cyc(HALF);
      spi_clk  = cpol;
      if (first + i < 16) rd = {rd[14:0], spi_miso};
      wait_cyc(HALF);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] miso_w;
    exp_t        e;
    if (v.kind != 0) begin
      e.kind  = v.kind;
      e.rdata = v.exp_rdata;
      exp_q.push_back(e);
    end
    spi_clk   = v.mode[1];
    spi_mode  = v.mode;
    spi_sdata = v.sdata;
    wait_cyc(6);
    spi_csn = 1'b0;
    wait_cyc(HALF);
    chk("busy_in_frame", {31'd0, spi_busy}, 1);
    chk("oe_in_frame", {31'd0, spi_miso_oe}, 1);
    // Changing inputs mid-frame must not disturb the captured mode or word
    spi_mode  = {~v.mode[1], v.mode[0]};
    spi_sdata = ~v.sdata;
    clk_bits(v.mode[1], v.mosi_w, 0, v.nclk, miso_w);
    spi_csn = 1'b1;
    wait_cyc(4);
    chk("busy_after_csn", {31'd0, spi_busy}, 0);
    chk("oe_after_csn", {31'd0, spi_miso_oe}, 0);
    drain();
    chk("rdata_after_frame", {16'd0, spi_rdata}, {16'd0, v.exp_rdata});
    if (v.chk_miso) chk("master_read", {16'd0, miso_w}, {16'd0, v.sdata});
    spi_mode  = v.mode;
    spi_sdata = v.sdata;
    wait_cyc(8);
  endtask

  initial begin
    logic [15:0] dummy;
    logic        miso_prev;
    vec_t        v5555;

    checks   = 0;
    failures = 0;
    rd_idx   = 0;

    vecs[0] = '{2'd1, 16'h3C5A, 16'hA5C3, 16, 1, 16'hA5C3, 1'b1};
    vecs[1] = '{2'd3, 16'hFFFF, 16'h8000, 16, 1, 16'h8000, 1'b1};
    vecs[2] = '{2'd3, 16'h0001, 16'h1234, 16, 1, 16'h1234, 1'b1};
    vecs[3] = '{2'd0, 16'h9A6C, 16'h0F0F, 16, 1, 16'h0F0F, 1'b1};
    vecs[4] = '{2'd2, 16'h6DB6, 16'hF00D, 16, 1, 16'hF00D, 1'b1};
    vecs[5] = '{2'd1, 16'h1357, 16'hBEEF, 18, 1, 16'hBEEF, 1'b1};
    vecs[6] = '{2'd3, 16'hAAAA, 16'h0123,  7, 2, 16'hBEEF, 1'b0};
    vecs[7] = '{2'd1, 16'hC3A5, 16'h5AA5, 16, 1, 16'h5AA5, 1'b1};

    rst_n     = 1'b0;
    spi_csn   = 1'b1;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    spi_mode  = 2'd1;
    spi_sdata = 16'h0000;
    wait_cyc(3);
    chk("reset_rdata", {16'd0, spi_rdata}, 0);
    chk("reset_done", {31'd0, spi_done}, 0);
    chk("reset_err", {31'd0, spi_err}, 0);
    chk("reset_busy", {31'd0, spi_busy}, 0);
    chk("reset_miso", {31'd0, spi_miso}, 0);
    chk("reset_oe", {31'd0, spi_miso_oe}, 0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Clock noise with chip select high must be ignored
    miso_prev = spi_miso;
    for (int i = 0; i < 20; i++) begin
      spi_clk = ~spi_clk;
      wait_cyc(5);
    end
    chk("noise_busy", {31'd0, spi_busy}, 0);
    chk("noise_oe", {31'd0, spi_miso_oe}, 0);
    chk("noise_rdata", {16'd0, spi_rdata}, 0);
    chk("noise_miso", {31'd0, spi_miso}, {31'd0, miso_prev});
    drain();

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
    end

    // Reset in the middle of a frame, released while csn is still low
    spi_clk   = 1'b0;
    spi_mode  = 2'd1;
    spi_sdata = 16'hF0F0;
    wait_cyc(6);
    spi_csn = 1'b0;
    wait_cyc(HALF);
    clk_bits(1'b0, 16'hFFFF, 0, 9, dummy);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("midrst_rdata", {16'd0, spi_rdata}, 0);
    chk("midrst_done", {31'd0, spi_done}, 0);
    chk("midrst_err", {31'd0, spi_err}, 0);
    chk("midrst_busy", {31'd0, spi_busy}, 0);
    chk("midrst_miso", {31'd0, spi_miso}, 0);
    chk("midrst_oe", {31'd0, spi_miso_oe}, 0);
    rst_n = 1'b1;
    wait_cyc(6);
    chk("postrst_busy", {31'd0, spi_busy}, 0);
    clk_bits(1'b0, 16'hFFFF, 9, 7, dummy);
    wait_cyc(HALF);
    chk("postrst_busy_end", {31'd0, spi_busy}, 0);
    chk("postrst_rdata", {16'd0, spi_rdata}, 0);
    drain();
    spi_csn = 1'b1;
    wait_cyc(8);

    v5555 = '{2'd1, 16'h0F35, 16'h5555, 16, 1, 16'h5555, 1'b1};
    run_frame(v5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
